// File: rtl/pwm_cfg_scheduler.sv
// PWM configuration register file with staged/active copies and a shared PWM timebase.
// Writes land in the staged copy and move to the active copy atomically, either at a
// PWM period boundary or on an explicit commit write, so outputs never change mid-period.
//
// Write handshake: a transfer happens on the rising clk edge where wr_valid && wr_ready.
// The master holds wr_addr/wr_data stable while wr_valid is high and not yet accepted.
// wr_ready depends only on internal state, never on wr_valid. It drops for exactly the
// boundary cycle so that a write can never race a commit.
module pwm_cfg_scheduler #(
  parameter int CLK_DIV = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_err,
  output logic        pending,
  output logic        period_start,
  output logic [7:0]  pwm_cnt,
  output logic [15:0] en_out_act,
  output logic [15:0] en_pwm_act,
  output logic [7:0]  duty_act,
  output logic [15:0] pwm_out
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic [15:0]   en_out_stg;
  logic [15:0]   en_pwm_stg;
  logic [7:0]    duty_stg;

  logic          step;
  logic          boundary;
  logic          accept;
  logic          stage_wr;
  logic          force_commit;
  logic          do_commit;
  logic          map_err;
  logic          lvl;
  logic [15:0]   pwm_next;

  // Decode timebase events and the write being accepted this cycle.
  always_comb begin
    step         = (presc == PRESC_LAST);
    boundary     = step && (pwm_cnt == 8'hFF);
    wr_ready     = ~boundary;
    accept       = wr_valid && wr_ready;
    stage_wr     = accept && (wr_addr <= 7'd4);
    force_commit = accept && (wr_addr == 7'd5) && wr_data[0];
    map_err      = accept && (wr_addr >= 7'd6);
    do_commit    = (boundary && pending) || force_commit;
    // Duty 255 is forced high so the last counter step does not drop out.
    lvl          = (duty_act == 8'hFF) || (pwm_cnt < duty_act);
    pwm_next     = en_out_act & (~en_pwm_act | {16{lvl}});
  end

  // Prescaler and PWM period counter; period_start marks the first clk of count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      pwm_cnt      <= 8'h00;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (step) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Staged register writes; the last write to each byte before a commit wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_stg <= 16'h0000;
      en_pwm_stg <= 16'h0000;
      duty_stg   <= 8'h00;
    end else if (stage_wr) begin
      case (wr_addr[2:0])
        3'd0:    en_out_stg[7:0]  <= wr_data;
        3'd1:    en_out_stg[15:8] <= wr_data;
        3'd2:    en_pwm_stg[7:0]  <= wr_data;
        3'd3:    en_pwm_stg[15:8] <= wr_data;
        default: duty_stg         <= wr_data;
      endcase
    end
  end

  // Atomic commit of all active registers, pending tracking and unmapped-address pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_act <= 16'h0000;
      en_pwm_act <= 16'h0000;
      duty_act   <= 8'h00;
      pending    <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      wr_err <= map_err;
      // A staging write and a commit never share an edge: only one write per edge,
      // and no write is accepted on the boundary cycle.
      if (do_commit) begin
        en_out_act <= en_out_stg;
        en_pwm_act <= en_pwm_stg;
        duty_act   <= duty_stg;
        pending    <= 1'b0;
      end else if (stage_wr) begin
        pending <= 1'b1;
      end
    end
  end

  // Registered output pins computed from the current active registers and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 16'h0000;
    end else begin
      pwm_out <= pwm_next;
    end
  end

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Bench for pwm_cfg_scheduler with CLK_DIV=2 (512 clk per PWM period).
module tb_pwm_cfg_scheduler;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_err;
  logic        pending;
  logic        period_start;
  logic [7:0]  pwm_cnt;
  logic [15:0] en_out_act;
  logic [15:0] en_pwm_act;
  logic [7:0]  duty_act;
  logic [15:0] pwm_out;

  int n_checks = 0;
  int n_errors = 0;

  // Staged-register model and expected active contents {en_out, en_pwm, duty}.
  logic [15:0] m_en_out;
  logic [15:0] m_en_pwm;
  logic [7:0]  m_duty;
  logic [39:0] exp_q[$];

  pwm_cfg_scheduler #(.CLK_DIV(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .pending      (pending),
    .period_start (period_start),
    .pwm_cnt      (pwm_cnt),
    .en_out_act   (en_out_act),
    .en_pwm_act   (en_pwm_act),
    .duty_act     (duty_act),
    .pwm_out      (pwm_out)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Driver: one write, returning wr_err as seen in the cycle after acceptance.
  task automatic wr(input logic [6:0] a, input logic [7:0] d, output logic err);
    int n;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    n = 0;
    while (!wr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) check_eq("wr_timeout", 64'd0, 64'd1);
    @(negedge clk);
    err      = wr_err;
    wr_valid = 1'b0;
    case (a)
      7'd0: m_en_out[7:0]  = d;
      7'd1: m_en_out[15:8] = d;
      7'd2: m_en_pwm[7:0]  = d;
      7'd3: m_en_pwm[15:8] = d;
      7'd4: m_duty         = d;
      default: ;
    endcase
  endtask

  task automatic push_expected();
    exp_q.push_back({m_en_out, m_en_pwm, m_duty});
  endtask

  // Scoreboard: compare active registers against the oldest expected commit.
  task automatic pop_compare(input string tag);
    logic [39:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_underflow"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {24'd0, en_out_act, en_pwm_act, duty_act}, {24'd0, e});
    end
  endtask

  task automatic wait_period_start();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 600);
    if (!period_start) check_eq("period_timeout", 64'd0, 64'd1);
  endtask

  // Count cycles with pwm_out[0] high over one full period; other pins must stay low.
  task automatic measure(input string tag, input int exp_high);
    int high;
    int stray;
    high  = 0;
    stray = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (pwm_out[0]) high++;
      if (pwm_out[15:1] != 15'd0) stray++;
    end
    check_eq({tag, "_high"}, 64'(high), 64'(exp_high));
    check_eq({tag, "_low"}, 64'(512 - high), 64'(512 - exp_high));
    check_eq({tag, "_stray"}, 64'(stray), 64'd0);
  endtask

  initial begin
    logic err;
    int bad;
    int n;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 7'd0;
    wr_data  = 8'd0;
    m_en_out = 16'h0;
    m_en_pwm = 16'h0;
    m_duty   = 8'h0;

    // 1: reset values and timebase rate
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {pwm_out, en_out_act, en_pwm_act, duty_act},
             64'd0);
    check_eq("rst_flags", {61'd0, wr_err, pending, period_start}, 64'd0);
    check_eq("rst_cnt", 64'(pwm_cnt), 64'd0);
    check_eq("rst_ready", 64'(wr_ready), 64'd1);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_eq("cnt_step", 64'(pwm_cnt), 64'(k / 2));
    end

    // 2: staged writes held until boundary
    wr(7'd0, 8'hFF, err);
    wr(7'd4, 8'h80, err);
    check_eq("t2_pending", 64'(pending), 64'd1);
    check_eq("t2_act_held", {40'd0, en_out_act, duty_act}, 64'd0);
    push_expected();
    wait_period_start();
    pop_compare("t2_commit");
    check_eq("t2_pending_clr", 64'(pending), 64'd0);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm_out !== 16'h00FF) bad++;
      @(negedge clk);
    end
    check_eq("t2_pwm_static", 64'(bad), 64'd0);

    // 3: PWM duty on pin 0
    wr(7'd0, 8'h01, err);
    wr(7'd1, 8'h00, err);
    wr(7'd2, 8'h01, err);
    wr(7'd3, 8'h00, err);
    wr(7'd4, 8'h40, err);
    push_expected();
    wait_period_start();
    pop_compare("t3_commit40");
    measure("duty40", 128);
    wr(7'd4, 8'h00, err);
    push_expected();
    wait_period_start();
    pop_compare("t3_commit00");
    measure("duty00", 0);
    wr(7'd4, 8'hFF, err);
    push_expected();
    wait_period_start();
    pop_compare("t3_commitFF");
    measure("dutyFF", 512);

    // 4: write offered exactly on the boundary cycle
    wait_period_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pwm_cnt != 8'hFF && n < 600);
    @(negedge clk);
    check_eq("t4_ready_bnd", 64'(wr_ready), 64'd0);
    wr_valid = 1'b1;
    wr_addr  = 7'd4;
    wr_data  = 8'h33;
    @(negedge clk);
    check_eq("t4_pstart", 64'(period_start), 64'd1);
    check_eq("t4_ready_after", 64'(wr_ready), 64'd1);
    check_eq("t4_duty_held", 64'(duty_act), 64'hFF);
    @(negedge clk);
    wr_valid = 1'b0;
    check_eq("t4_pending", 64'(pending), 64'd1);
    check_eq("t4_no_commit", 64'(duty_act), 64'hFF);
    m_duty = 8'h33;
    push_expected();
    wait_period_start();
    pop_compare("t4_commit");

    // 5: forced commit, no-op commit and unmapped address
    wait_period_start();
    wr(7'd4, 8'h20, err);
    check_eq("t5_pending", 64'(pending), 64'd1);
    push_expected();
    wr(7'd5, 8'h01, err);
    pop_compare("t5_force");
    check_eq("t5_pending_clr", 64'(pending), 64'd0);
    wr(7'd4, 8'h21, err);
    wr(7'd5, 8'hFE, err);
    check_eq("t5_noop_duty", 64'(duty_act), 64'h20);
    check_eq("t5_noop_pend", 64'(pending), 64'd1);
    wr(7'h10, 8'hAA, err);
    check_eq("t5_err_pulse", 64'(err), 64'd1);
    @(negedge clk);
    check_eq("t5_err_clear", 64'(wr_err), 64'd0);
    check_eq("t5_unmapped_regs", {24'd0, en_out_act, en_pwm_act, duty_act},
             {24'd0, 16'h0001, 16'h0001, 8'h20});

    // 6: asynchronous reset with pending staged data
    check_eq("t6_pending_pre", 64'(pending), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_async_outs", {pwm_out, en_out_act, en_pwm_act, duty_act}, 64'd0);
    check_eq("t6_async_flags", {53'd0, pwm_cnt, wr_err, pending, period_start}, 64'd0);
    check_eq("t6_async_ready", 64'(wr_ready), 64'd1);
    m_en_out = 16'h0;
    m_en_pwm = 16'h0;
    m_duty   = 8'h0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_period_start();
    @(negedge clk);
    check_eq("t6_no_commit", {pwm_out, en_out_act, en_pwm_act, duty_act}, 64'd0);
    check_eq("t6_pending", 64'(pending), 64'd0);

    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
